// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Shared definitions for the AXI4-Lite bridges on the external endpoint.
//   AXI_RESP_OKAY / AXI_RESP_SLVERR : R/B response encodings.
//   axil_rd_state_e                 : read bridge FSM states.
// -----------------------------------------------------------------------------
package axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXT  = 1'b1
  } axil_rd_state_e;

endpackage

// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo
// Small synchronous FIFO used as a response buffer. DEPTH=1 builds a single
// holding register; larger depths build a ring buffer. Storage is cleared on
// reset so dout reads as zero until the first push.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   psh      in   push din (ignored when full and not popping)
//   din      in   WIDTH data to push
//   pop      in   pop the head entry (ignored when empty)
//   dout     out  WIDTH head entry
//   dout_val out  head entry valid (not empty)
//   full     out  no free entry
// -----------------------------------------------------------------------------
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             psh,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             dout_val,
  output logic             full
);

  generate
    if (DEPTH == 1) begin : g_single
      logic [WIDTH-1:0] data_q, data_d;
      logic             val_q, val_d;
      logic             push_ok_s;

      // Single entry: a push is taken when empty or when the entry leaves now.
      always_comb begin
        push_ok_s = psh & (~val_q | pop);
        data_d    = data_q;
        val_d     = val_q;
        if (push_ok_s) begin
          data_d = din;
          val_d  = 1'b1;
        end else if (pop) begin
          val_d  = 1'b0;
        end else begin
          val_d  = val_q;
        end
      end

      // Holding register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= {WIDTH{1'b0}};
          val_q  <= 1'b0;
        end else begin
          data_q <= data_d;
          val_q  <= val_d;
        end
      end

      assign dout     = data_q;
      assign dout_val = val_q;
      assign full     = val_q;
    end else begin : g_ring
      localparam int PW = $clog2(DEPTH);
      localparam int CW = $clog2(DEPTH + 1);

      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [WIDTH-1:0] mem_d [DEPTH];
      logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
      logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
      logic [CW-1:0]    cnt_q, cnt_d;
      logic             push_ok_s, pop_ok_s;

      // Ring pointers and occupancy.
      always_comb begin
        pop_ok_s  = pop & (cnt_q != {CW{1'b0}});
        push_ok_s = psh & ((cnt_q != CW'(DEPTH)) | pop_ok_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (push_ok_s) begin
          mem_d[wr_ptr_q] = din;
          wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
          rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
        end else begin
          rd_ptr_d = rd_ptr_q;
        end
        if (push_ok_s && !pop_ok_s) begin
          cnt_d = cnt_q + CW'(1);
        end else if (pop_ok_s && !push_ok_s) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end

      // Ring storage and pointers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
          end
          wr_ptr_q <= {PW{1'b0}};
          rd_ptr_q <= {PW{1'b0}};
          cnt_q    <= {CW{1'b0}};
        end else begin
          mem_q    <= mem_d;
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          cnt_q    <= cnt_d;
        end
      end

      assign dout     = mem_q[rd_ptr_q];
      assign dout_val = (cnt_q != {CW{1'b0}});
      assign full     = (cnt_q == CW'(DEPTH));
    end
  endgenerate

endmodule

// File: rtl/axil_rd_ext.sv
// -----------------------------------------------------------------------------
// axil_rd_ext
// AXI4-Lite read slave bridging single-beat reads at MEM_BASE onto an external
// request/response read port. One transaction outstanding at a time; reads to
// any other address return SLVERR without touching the external side.
// Optional feature macro: AXIL_RD_TIMEOUT_EN -- abandon an external read that
// gets no response within TIMEOUT_CYCLES cycles and answer SLVERR.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   axi_araddr/arvalid/arready AR channel
//   axi_rdata/rresp/rvalid/rready R channel (driven from a 1-entry buffer)
//   ext_rd_req                 external read request, level, held until response
//   ext_rsp_val, ext_rd_dat    external single-cycle response and its data
// -----------------------------------------------------------------------------
module axil_rd_ext
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE       = ADDR_WIDTH'(32'h1000_0000),
  parameter int                    TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  output logic [DATA_WIDTH-1:0] axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic                  ext_rd_req,
  input  logic                  ext_rsp_val,
  input  logic [DATA_WIDTH-1:0] ext_rd_dat
);

  localparam int RW = DATA_WIDTH + 2;

  axil_rd_state_e  state_q, state_d;
  logic            push_s;
  logic [RW-1:0]   push_data_s;
  logic            pop_s;
  logic            full_s;
  logic            rvalid_s;
  logic [RW-1:0]   rsp_s;
  logic            ar_hs_s;
  logic            addr_hit_s;
  logic            to_expired_s;

  // AR is only taken in IDLE with room for the answer, so the buffer can never
  // overflow and a pop never coincides with an accept.
  always_comb begin
    axi_arready = (state_q == IDLE) && !full_s;
    ext_rd_req  = (state_q == EXT);
    ar_hs_s     = axi_arvalid & axi_arready;
    addr_hit_s  = (axi_araddr == MEM_BASE);
    pop_s       = rvalid_s & axi_rready;
  end

`ifdef AXIL_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Counts EXT cycles from zero; it sits at zero in IDLE so each entry to
  // EXT starts a fresh count.
  always_comb begin
    if (state_q == EXT) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end else begin
      to_cnt_d = {TW{1'b0}};
    end
    to_expired_s = (state_q == EXT) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= {TW{1'b0}};
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  // Without the timeout the external read waits indefinitely.
  always_comb begin
    to_expired_s = 1'b0;
  end
`endif

  // Next state and response-buffer push. A response in the expiry cycle
  // wins over the timeout.
  always_comb begin
    state_d     = state_q;
    push_s      = 1'b0;
    push_data_s = {RW{1'b0}};
    case (state_q)
      IDLE: begin
        if (ar_hs_s) begin
          if (addr_hit_s) begin
            state_d = EXT;
          end else begin
            push_s      = 1'b1;
            push_data_s = {{DATA_WIDTH{1'b0}}, AXI_RESP_SLVERR};
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXT: begin
        if (ext_rsp_val) begin
          push_s      = 1'b1;
          push_data_s = {ext_rd_dat, AXI_RESP_OKAY};
          state_d     = IDLE;
        end else if (to_expired_s) begin
          push_s      = 1'b1;
          push_data_s = {{DATA_WIDTH{1'b0}}, AXI_RESP_SLVERR};
          state_d     = IDLE;
        end else begin
          state_d = EXT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  fifo #(
    .WIDTH (RW),
    .DEPTH (1)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .psh      (push_s),
    .din      (push_data_s),
    .pop      (pop_s),
    .dout     (rsp_s),
    .dout_val (rvalid_s),
    .full     (full_s)
  );

  assign axi_rvalid = rvalid_s;
  assign axi_rdata  = rsp_s[RW-1:2];
  assign axi_rresp  = rsp_s[1:0];

endmodule

// File: tb/tb_axil_rd_ext.sv
// -----------------------------------------------------------------------------
// tb_axil_rd_ext
// Bench for axil_rd_ext: a directed cycle table, hand-written reset and
// timeout sequences, then randomized traffic against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_axil_rd_ext;

  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          TO   = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef AXIL_RD_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] axi_araddr;
  logic          axi_arvalid;
  logic          axi_arready;
  logic [DW-1:0] axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rvalid;
  logic          axi_rready;
  logic          ext_rd_req;
  logic          ext_rsp_val;
  logic [DW-1:0] ext_rd_dat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axil_rd_ext #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .MEM_BASE       (BASE),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .axi_araddr  (axi_araddr),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .ext_rd_req  (ext_rd_req),
    .ext_rsp_val (ext_rsp_val),
    .ext_rd_dat  (ext_rd_dat)
  );

  typedef struct {
    logic        av;
    logic [31:0] ad;
    logic        rr;
    logic        rv;
    logic [31:0] d;
    logic        e_ar;
    logic        e_req;
    logic        e_v;
    logic [31:0] e_d;
    logic [1:0]  e_r;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic av, logic [31:0] ad, logic rr, logic rv, logic [31:0] d,
                              logic e_ar, logic e_req, logic e_v, logic [31:0] e_d, logic [1:0] e_r);
    vec_t v;
    v.av = av; v.ad = ad; v.rr = rr; v.rv = rv; v.d = d;
    v.e_ar = e_ar; v.e_req = e_req; v.e_v = e_v; v.e_d = e_d; v.e_r = e_r;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Outputs depend only on state, so they are checked before the edge.
  task automatic check_outs(input string tag, input logic ea, input logic ereq, input logic ev,
                            input logic [31:0] ed, input logic [1:0] er, input bit force_data);
    chk({tag, ".arready"}, 64'(axi_arready), 64'(ea));
    chk({tag, ".ext_rd_req"}, 64'(ext_rd_req), 64'(ereq));
    chk({tag, ".rvalid"}, 64'(axi_rvalid), 64'(ev));
    if (ev || force_data) begin
      chk({tag, ".rdata"}, 64'(axi_rdata), 64'(ed));
      chk({tag, ".rresp"}, 64'(axi_rresp), 64'(er));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    axi_arvalid = 1'b0;
    axi_araddr  = 32'h0;
    axi_rready  = 1'b0;
    ext_rsp_val = 1'b0;
    ext_rd_dat  = 32'h0;
  endtask

  // Model state for the random phase.
  bit          m_busy;
  int          m_age;
  logic [33:0] m_q[$];

  initial begin
    logic [36:0] act;
    logic [36:0] exp;
    logic        e_ar, e_req, e_v;
    logic [33:0] e_rsp;
    bit          av_hold;
    int          r;

    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    check_outs("reset", 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
    rst_n = 1'b1;

    // Good read, response in the third request cycle.
    vecs.push_back(mk(1'b1, BASE, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0, 2'b00));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 32'h0, 2'b00));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 32'h0, 2'b00));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 2'b00));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0, 2'b00));
    // Bad address.
    vecs.push_back(mk(1'b1, BASE + 32'd4, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h0, 2'b10));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0, 2'b00));
    // Stray response in IDLE.
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0, 2'b00));
    // Minimum latency read, then R backpressure with a second AR pending.
    vecs.push_back(mk(1'b1, BASE, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0, 2'b00));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00));
    vecs.push_back(mk(1'b1, BASE, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678, 2'b00));
    vecs.push_back(mk(1'b1, BASE, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678, 2'b00));
    vecs.push_back(mk(1'b1, BASE, 1'b0, 1'b1, 32'hBAD0BAD0, 1'b0, 1'b0, 1'b1, 32'h12345678, 2'b00));
    vecs.push_back(mk(1'b1, BASE, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678, 2'b00));
    vecs.push_back(mk(1'b1, BASE, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678, 2'b00));
    vecs.push_back(mk(1'b1, BASE, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678, 2'b00));
    vecs.push_back(mk(1'b1, BASE, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0, 2'b00));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 32'h0, 2'b00));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h00000055, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h00000055, 2'b00));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0, 2'b00));
    // Address just below the window.
    vecs.push_back(mk(1'b1, BASE - 32'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h0, 2'b10));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h0, 2'b00));

    for (int i = 0; i < vecs.size(); i++) begin
      axi_arvalid = vecs[i].av;
      axi_araddr  = vecs[i].ad;
      axi_rready  = vecs[i].rr;
      ext_rsp_val = vecs[i].rv;
      ext_rd_dat  = vecs[i].d;
      check_outs($sformatf("vec%0d", i), vecs[i].e_ar, vecs[i].e_req, vecs[i].e_v,
                 vecs[i].e_d, vecs[i].e_r, 1'b0);
      tick();
    end
    idle_inputs();

    // Reset dropped mid-EXT: outputs return to reset values at once.
    axi_arvalid = 1'b1;
    axi_araddr  = BASE;
    tick();
    idle_inputs();
    tick();
    check_outs("midext", 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
    tick();
    rst_n = 1'b1;
    ext_rsp_val = 1'b1;
    ext_rd_dat  = 32'h77777777;
    tick();
    ext_rsp_val = 1'b0;
    check_outs("late_rsp", 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    axi_arvalid = 1'b1;
    axi_araddr  = BASE;
    tick();
    axi_arvalid = 1'b0;
    ext_rsp_val = 1'b1;
    ext_rd_dat  = 32'hA5A5A5A5;
    tick();
    idle_inputs();
    check_outs("after_rst", 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 2'b00, 1'b0);
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    check_outs("after_rst_pop", 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);

`ifdef AXIL_RD_TIMEOUT_EN
    // No response: SLVERR after TO EXT cycles.
    axi_arvalid = 1'b1; axi_araddr = BASE;
    tick();
    idle_inputs();
    for (int k = 0; k < TO; k++) begin
      check_outs($sformatf("to_wait%0d", k), 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
      tick();
    end
    check_outs("to_err", 1'b0, 1'b0, 1'b1, 32'h0, 2'b10, 1'b0);
    axi_rready = 1'b1; tick(); axi_rready = 1'b0;
    // Response in the last EXT cycle wins.
    axi_arvalid = 1'b1; axi_araddr = BASE;
    tick();
    idle_inputs();
    for (int k = 0; k < TO - 1; k++) tick();
    ext_rsp_val = 1'b1; ext_rd_dat = 32'hCAFEF00D;
    check_outs("to_last", 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    ext_rsp_val = 1'b0;
    check_outs("to_last_ok", 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 2'b00, 1'b0);
    axi_rready = 1'b1; tick(); axi_rready = 1'b0;
    // Response one cycle too late is ignored.
    axi_arvalid = 1'b1; axi_araddr = BASE;
    tick();
    idle_inputs();
    for (int k = 0; k < TO; k++) tick();
    ext_rsp_val = 1'b1; ext_rd_dat = 32'h0BADF00D;
    check_outs("to_late", 1'b0, 1'b0, 1'b1, 32'h0, 2'b10, 1'b0);
    tick();
    ext_rsp_val = 1'b0;
    check_outs("to_late_hold", 1'b0, 1'b0, 1'b1, 32'h0, 2'b10, 1'b0);
    axi_rready = 1'b1; tick(); axi_rready = 1'b0;
    check_outs("to_late_none", 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
`endif

    // Randomized traffic against the transaction model.
    rst_n = 1'b0;
    idle_inputs();
    #2;
    rst_n = 1'b1;
    tick();
    m_busy  = 1'b0;
    m_age   = 0;
    m_q.delete();
    av_hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!av_hold) begin
        axi_arvalid = ($urandom % 2) == 0;
        r = $urandom % 4;
        if (r < 2)       axi_araddr = BASE;
        else if (r == 2) axi_araddr = BASE + 32'd4;
        else             axi_araddr = $urandom;
      end
      axi_rready  = ($urandom % 3) != 0;
      ext_rsp_val = ($urandom % 4) == 0;
      ext_rd_dat  = $urandom;

      e_ar  = !m_busy && (m_q.size() == 0);
      e_req = m_busy;
      e_v   = (m_q.size() != 0);
      e_rsp = e_v ? m_q[0] : 34'd0;
      act = {axi_arready, ext_rd_req, axi_rvalid, axi_rvalid ? {axi_rdata, axi_rresp} : 34'd0};
      exp = {e_ar, e_req, e_v, e_rsp};
      chk($sformatf("rand%0d", c), 64'(act), 64'(exp));

      if (e_v && axi_rready) void'(m_q.pop_front());
      if (m_busy) begin
        if (ext_rsp_val) begin
          m_q.push_back({ext_rd_dat, 2'b00});
          m_busy = 1'b0;
        end else if (TIMEOUT_EN && (m_age == TO - 1)) begin
          m_q.push_back({32'h0, 2'b10});
          m_busy = 1'b0;
        end else begin
          m_age++;
        end
      end else if (axi_arvalid && e_ar) begin
        if (axi_araddr == BASE) begin
          m_busy = 1'b1;
          m_age  = 0;
        end else begin
          m_q.push_back({32'h0, 2'b10});
        end
      end
      av_hold = axi_arvalid && !e_ar;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_rd_ext.md
# axil_rd_ext

AXI4-Lite read-channel slave that bridges single-beat reads at `MEM_BASE` onto the external request/response read interface. It pairs with the AXI-Lite write bridge on the same external endpoint: it accepts AR, issues one external read request, waits for the response, and returns it on R. Reads to any other address complete immediately with SLVERR and never reach the external side.

## Interface
- `MEM_BASE`, default 32'h10000000: only decoded read address.
- `DATA_WIDTH`, default 32: R data / external data width.
- `ADDR_WIDTH`, default 32: AR address width.
- `TIMEOUT_CYCLES`, default 256: external response timeout, in cycles. Used only with `AXIL_RD_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `axi_araddr`  in  ADDR_WIDTH  read address.
- `axi_arvalid`  in  1  AR valid.
- `axi_arready`  out  1  AR ready.
- `axi_rdata`  out  DATA_WIDTH  read data.
- `axi_rresp`  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- `axi_rvalid`  out  1  R valid.
- `axi_rready`  in  1  R ready.
- `ext_rd_req`  out  1  external read request, level, held until response.
- `ext_rsp_val`  in  1  external response valid, single-cycle pulse.
- `ext_rd_dat`  in  DATA_WIDTH  external read data, sampled when `ext_rsp_val`=1.

## Operation
- FSM with two states.
  - **IDLE**:
    - `axi_arready` = 1 when the response buffer is not full; 0 otherwise.
    - On `arvalid & arready` with `araddr == MEM_BASE`: go to EXT.
    - On `arvalid & arready` with any other address: push {rdata=0, rresp=2'b10} into the response buffer and stay in IDLE.
  - **EXT**:
    - `ext_rd_req` = 1 and `axi_arready` = 0.
    - On `ext_rsp_val`: push {`ext_rd_dat`, 2'b00} and go to IDLE.
- The response buffer is one entry of {rdata, rresp}.
  - `axi_rvalid` = entry valid; `axi_rdata` / `axi_rresp` come from the entry.
  - The entry pops on `rvalid & rready`.
- At most one transaction is outstanding.
  - AR is not accepted while the buffer holds an unconsumed response; a pop and an AR accept in the same cycle are not allowed.
  - Entry to EXT requires an empty buffer, so a push from EXT never sees a full buffer.
- `ext_rsp_val` in IDLE is ignored: no push and no state change.
- R-channel stability: once `rvalid` = 1, `rdata` and `rresp` hold until the handshake, regardless of `ext_*` activity.
- Reset, including mid-transaction:
  - FSM returns to IDLE and the buffer empties.
  - `axi_arready`=1, `axi_rvalid`=0, `axi_rdata`=0, `axi_rresp`=2'b00, `ext_rd_req`=0.
  - The in-flight external read is abandoned; a response arriving after reset is ignored.

## Timing
- `axi_arready` and `ext_rd_req` are combinational from FSM state and buffer-full. No path runs from `axi_arvalid` or `axi_rready` to any output.
- Decode error: AR handshake in cycle N → `rvalid`=1 in N+1.
- Good read: AR handshake in N → `ext_rd_req`=1 from N+1. `ext_rsp_val` in M → `rvalid`=1 in M+1.
  - Minimum latency is AR→R 2 cycles (`ext_rsp_val` in N+1).
- Throughput: `rvalid & rready` in cycle K → `arready`=1 from K+1. The fastest back-to-back rate for good reads is one per 3 cycles.

## Configuration
- **`AXIL_RD_TIMEOUT_EN` defined**:
  - A counter clears on entry to EXT and increments each cycle in EXT.
  - When the counter reaches `TIMEOUT_CYCLES`-1 without `ext_rsp_val`: push {0, 2'b10}, drop `ext_rd_req`, go to IDLE.
  - `ext_rsp_val` in the expiry cycle takes priority: OKAY with data.
  - A late response after timeout is ignored (IDLE rule).
  - Counter width is $clog2(TIMEOUT_CYCLES)+1.
- **Not defined**: no counter; EXT waits indefinitely; `TIMEOUT_CYCLES` has no effect.

## Structure
- `axil_pkg` holds:
  - `AXI_RESP_OKAY` = 2'b00 and `AXI_RESP_SLVERR` = 2'b10, shared with the write bridge.
  - `axil_rd_state_e` {IDLE, EXT}.
- The response buffer is the codebase `fifo` sub-module, WIDTH=DATA_WIDTH+2, DEPTH=1.
  - Wiring: psh=push, pop=`rvalid & rready`, dout_val → `axi_rvalid`, full → arready gating.
  - `fifo` must use async active-low reset on `rst_n`.

## Test plan
- **Good read**: AR 0x10000000; `ext_rsp_val` 3 cycles after `ext_rd_req` with data 0xDEADBEEF; `rready`=1 → rdata=0xDEADBEEF, rresp=00, `ext_rd_req` high exactly 3 cycles.
- **Bad address**: AR 0x10000004 → `rvalid` next cycle, rdata=0, rresp=10, `ext_rd_req` never asserted.
- **R backpressure**: good read with data 0x12345678, `rready`=0 for 5 cycles, second AR pending → rdata stable, `arready`=0 until the handshake, second AR accepted the cycle after.
- **Stray/reset**:
  - `ext_rsp_val` pulse in IDLE → no R response.
  - `rst_n` dropped while in EXT → all outputs at reset values immediately.
  - After release, a new read with data 0xA5A5A5A5 returns correctly.
- **Timeout (`AXIL_RD_TIMEOUT_EN`, TIMEOUT_CYCLES=8)**:
  - No `ext_rsp_val` → SLVERR with rdata=0 after 8 EXT cycles.
  - Response on the 8th cycle → OKAY with data.
  - Response on the 9th cycle → ignored.
